// File: rtl/exec_issue_arbiter.sv
// Round-robin issue scheduler: picks one ready reservation-station port per
// cycle and launches its cell into a registered execute-input stage. The
// launched op is held under downstream backpressure and squashed on flush.
//
// Handshake: a requester sees its op accepted when req_grant[i] is high at a
// rising edge and dequeues it there. exec_op is consumed at a rising edge
// where exec_valid && exec_ready; while exec_valid && !exec_ready the op and
// exec_valid stay bit-stable until consumed or flushed.

package exec_issue_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  optype;
      logic [5:0]  dst_tag;
      logic [15:0] imm;
   } res_st_cell_t;
endpackage

module exec_issue_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ),
   parameter int CNT_W   = 16
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 flush,
   input  logic [NUM_REQ-1:0]                                   req_valid,
   input  logic [NUM_REQ*$bits(exec_issue_pkg::res_st_cell_t)-1:0] req_op,
   output logic [NUM_REQ-1:0]                                   req_grant,
   output logic                                                 exec_valid,
   output logic [$bits(exec_issue_pkg::res_st_cell_t)-1:0]      exec_op,
   input  logic                                                 exec_ready,
   output logic [CNT_W-1:0]                                     stall_cnt
);

   localparam int OP_W = $bits(exec_issue_pkg::res_st_cell_t);
   localparam logic [PTR_W:0]   NUM_REQ_W = NUM_REQ[PTR_W:0];
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] sel;
   logic [PTR_W:0]   idx;
   logic             found;
   logic             load_en;
   logic             grant_fire;
   logic             stall_now;
   logic [OP_W-1:0]  op_arr [NUM_REQ];

   // Unpack the flat candidate bus into one cell per port.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr[g] = req_op[g*OP_W +: OP_W];
   end

   // Stage can accept a new op when empty or being drained, unless flushed.
   assign load_en    = !flush && (!exec_valid || exec_ready);
   assign grant_fire = rst_n && load_en && found;
   assign stall_now  = exec_valid && !exec_ready && !flush;

   // Scan from rr_ptr upward (modulo NUM_REQ) for the first valid requester.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + k[PTR_W:0];
         if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
         if (!found && req_valid[idx[PTR_W-1:0]]) begin
            found = 1'b1;
            sel   = idx[PTR_W-1:0];
         end
      end
   end

   // One-hot grant to the selected port, only when the stage can load.
   always_comb begin
      req_grant = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         req_grant[j] = grant_fire && (sel == j[PTR_W-1:0]);
      end
   end

   // Execute-input register and round-robin pointer; flush wins over load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_valid <= 1'b0;
         exec_op    <= '0;
         rr_ptr     <= '0;
      end else if (flush) begin
         exec_valid <= 1'b0;
      end else if (load_en) begin
         exec_valid <= found;
         if (found) begin
            exec_op <= op_arr[sel];
            rr_ptr  <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
         end
      end
   end

   // Saturating count of cycles the held op is blocked by the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_now && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_exec_issue_arbiter.sv
// Bench for exec_issue_arbiter: directed vector table, hand sequences for
// backpressure, flush, saturation and async reset, then random traffic
// compared with a cycle-level reference model.

module tb_exec_issue_arbiter;
   import exec_issue_pkg::*;

   localparam int N     = 4;
   localparam int CNT_W = 4;
   localparam int OP_W  = $bits(res_st_cell_t);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic               flush = 1'b0;
   logic [N-1:0]       req_valid = '0;
   logic [N*OP_W-1:0]  req_op = '0;
   logic [N-1:0]       req_grant;
   logic               exec_valid;
   logic [OP_W-1:0]    exec_op;
   logic               exec_ready = 1'b0;
   logic [CNT_W-1:0]   stall_cnt;

   exec_issue_arbiter #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_op(req_op), .req_grant(req_grant),
      .exec_valid(exec_valid), .exec_op(exec_op),
      .exec_ready(exec_ready), .stall_cnt(stall_cnt)
   );

   int checks = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   logic [OP_W-1:0] ops [N];
   logic            m_valid;
   logic [OP_W-1:0] m_op;
   int              m_ptr;
   int              m_stall;
   logic [OP_W-1:0] exp_q[$];   // ops expected at exec_op, in grant order

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_op    = '0;
      m_ptr   = 0;
      m_stall = 0;
      exp_q.delete();
   endtask

   function automatic logic [OP_W-1:0] mk_op(input logic [31:0] pc);
      res_st_cell_t c;
      c.pc      = pc;
      c.optype  = 4'($urandom_range(0, 15));
      c.dst_tag = 6'($urandom_range(0, 63));
      c.imm     = 16'($urandom);
      return c;
   endfunction

   // One clock cycle: drive, check mid-cycle against the model, advance.
   task automatic cycle(input logic f, input logic [N-1:0] v, input logic r,
                        output logic [N-1:0] grant_seen);
      int gi;
      logic load;
      logic [N-1:0] eg;
      flush = f; req_valid = v; exec_ready = r;
      for (int i = 0; i < N; i++) req_op[i*OP_W +: OP_W] = v[i] ? ops[i] : 'x;
      @(negedge clk);
      gi = -1;
      for (int k = 0; k < N; k++)
         if (gi < 0 && v[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
      load = !f && (!m_valid || r);
      eg = (load && gi >= 0) ? N'(1 << gi) : '0;
      grant_seen = req_grant;
      chk("req_grant", 64'(req_grant), 64'(eg));
      chk("exec_valid", 64'(exec_valid), 64'(m_valid));
      if (m_valid) chk("exec_op", 64'(exec_op), 64'(m_op));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      @(posedge clk);
      if (m_valid && !r && !f && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (f) m_valid = 1'b0;
      else if (load) begin
         if (gi >= 0) begin
            m_op = ops[gi]; m_valid = 1'b1; m_ptr = (gi + 1) % N;
            exp_q.push_back(ops[gi]);
         end else m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush = 1'b0; req_valid = '0; exec_ready = 1'b0;
      #1;
      chk("rst_grant", 64'(req_grant), 64'h0);
      chk("rst_valid", 64'(exec_valid), 64'h0);
      chk("rst_op", 64'(exec_op), 64'h0);
      chk("rst_stall", 64'(stall_cnt), 64'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         f;
      logic [N-1:0] v;
      logic         r;
      logic [N-1:0] exp_grant;
   } vec_t;

   vec_t vecs [9];
   logic [N-1:0] g;
   logic [OP_W-1:0] held;

   initial begin
      // Skip/wrap from pointer 0, then fairness rotation over all four ports.
      vecs[0] = '{1'b0, 4'b0100, 1'b1, 4'b0100};
      vecs[1] = '{1'b0, 4'b1010, 1'b1, 4'b1000};
      vecs[2] = '{1'b0, 4'b1111, 1'b1, 4'b0001};
      vecs[3] = '{1'b0, 4'b1111, 1'b1, 4'b0010};
      vecs[4] = '{1'b0, 4'b1111, 1'b1, 4'b0100};
      vecs[5] = '{1'b0, 4'b1111, 1'b1, 4'b1000};
      vecs[6] = '{1'b0, 4'b1111, 1'b1, 4'b0001};
      vecs[7] = '{1'b0, 4'b0000, 1'b1, 4'b0000};
      vecs[8] = '{1'b0, 4'b0010, 1'b0, 4'b0010};

      for (int i = 0; i < N; i++) ops[i] = mk_op(32'(i * 4));
      do_reset();

      for (int t = 0; t < 9; t++) begin
         cycle(vecs[t].f, vecs[t].v, vecs[t].r, g);
         chk($sformatf("vec%0d_grant", t), 64'(g), 64'(vecs[t].exp_grant));
      end
      // The fairness window must have presented pc 0,4,8,C,0 in that order.
      chk("pc_order", 64'(exec_op[OP_W-1 -: 32]), 64'h4);

      // Backpressure: port 1's op is live, consumer stalls for 3 cycles.
      held = exec_op;
      for (int t = 0; t < 3; t++) begin
         cycle(1'b0, 4'b1111, 1'b0, g);
         chk("bp_grant", 64'(g), 64'h0);
         chk("bp_hold", 64'(exec_op), 64'(held));
      end
      chk("bp_stall3", 64'(stall_cnt), 64'h3);
      cycle(1'b0, 4'b1111, 1'b1, g);      // consume + new grant same edge
      chk("b2b_grant", 64'(g), 64'b0100);
      chk("b2b_pc", 64'(exec_op[OP_W-1 -: 32]), 64'h8);

      // Flush while holding: no grant, valid drops, pointer and count stay.
      cycle(1'b0, 4'b1111, 1'b0, g);
      cycle(1'b1, 4'b1111, 1'b0, g);
      chk("flush_grant", 64'(g), 64'h0);
      chk("flush_stall", 64'(stall_cnt), 64'h4);
      cycle(1'b0, 4'b1111, 1'b0, g);
      chk("post_flush_grant", 64'(g), 64'b1000);

      // Saturation: hold for 20 cycles.
      for (int t = 0; t < 20; t++) cycle(1'b0, 4'b1111, 1'b0, g);
      chk("stall_sat", 64'(stall_cnt), 64'hF);

      // Asynchronous reset in the middle of a hold.
      #2;
      chk("pre_rst_valid", 64'(exec_valid), 64'h1);
      do_reset();
      cycle(1'b0, 4'b1111, 1'b1, g);
      chk("post_rst_grant", 64'(g), 64'b0001);

      // Random traffic with X on unrequested payloads.
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < N; i++) ops[i] = mk_op($urandom);
         cycle($urandom_range(0, 9) == 0, N'($urandom_range(0, 15)),
               $urandom_range(0, 3) != 0, g);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
